// File: rtl/steering_pkg.sv
// steering_pkg: shared widths and state encoding for the steering PWM driver
package steering_pkg;

    localparam int CTRL_W = 48;
    localparam int DUTY_W = 16;

    typedef enum logic [1:0] {IDLE, TRACK, FAILSAFE} steer_state_t;

endpackage

// File: rtl/steering_target_calc.sv
// steering_target_calc: captures a command, shifts and clamps it into a pulse-width target
module steering_target_calc
    import steering_pkg::*;
#(
    parameter int CENTER_CYCLES = 75,
    parameter int SPAN_CYCLES   = 25,
    parameter int SHIFT         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_value,
    output logic [DUTY_W-1:0] o_target,
    output logic              o_sat,
    output logic              o_target_valid
);

    localparam logic signed [CTRL_W-1:0] SPAN_S = CTRL_W'(SPAN_CYCLES);

    logic                     v1_q;
    logic signed [CTRL_W-1:0] val_q;
    logic                     tv_q;
    logic                     sat_q;
    logic [DUTY_W-1:0]        target_q;
    logic signed [CTRL_W-1:0] off;
    logic signed [CTRL_W-1:0] off_c;
    logic                     hi;
    logic                     lo;
    logic [DUTY_W-1:0]        target_d;

    // Clamp on the full-width offset so huge commands cannot alias after truncation
    always_comb begin
        off      = val_q >>> SHIFT;
        hi       = off > SPAN_S;
        lo       = off < -SPAN_S;
        off_c    = hi ? SPAN_S : lo ? -SPAN_S : off;
        target_d = DUTY_W'(off_c + CTRL_W'(CENTER_CYCLES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            val_q    <= '0;
            tv_q     <= 1'b0;
            sat_q    <= 1'b0;
            target_q <= DUTY_W'(CENTER_CYCLES);
        end else begin
            v1_q <= i_valid;
            if (i_valid)
                val_q <= i_value;
            tv_q <= v1_q;
            if (v1_q) begin
                target_q <= target_d;
                sat_q    <= hi | lo;
            end
        end
    end

    assign o_target       = target_q;
    assign o_sat          = sat_q;
    assign o_target_valid = tv_q;

endmodule

// File: rtl/steering_pwm_driver.sv
// steering_pwm_driver: slew-limited servo PWM from steering commands, with timeout failsafe
module steering_pwm_driver
    import steering_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 1000,
    parameter int CENTER_CYCLES  = 75,
    parameter int SPAN_CYCLES    = 25,
    parameter int SHIFT          = 16,
    parameter int SLEW_MAX       = 5,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ctrl_valid,
    input  logic [CTRL_W-1:0] i_ctrl_value,
    output logic              o_pwm,
    output logic              o_frame_start,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_sat,
    output logic              o_timeout
);

    localparam logic [DUTY_W-1:0] LAST    = DUTY_W'(PERIOD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] CENTER  = DUTY_W'(CENTER_CYCLES);
    localparam logic [DUTY_W-1:0] SLEW    = DUTY_W'(SLEW_MAX);
    localparam logic [DUTY_W-1:0] TO_LAST = DUTY_W'(TIMEOUT_FRAMES - 1);

    logic [DUTY_W-1:0] calc_target;
    logic              calc_sat;
    logic              calc_tv;

    logic              run_q;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] duty_out_q;
    logic              pwm_q;
    logic              fs_q;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] to_q, to_d;
    steer_state_t      state_q, state_d;
    logic              boundary;
    logic              up;
    logic [DUTY_W-1:0] diff;
    logic [DUTY_W-1:0] step;

    steering_target_calc #(
        .CENTER_CYCLES(CENTER_CYCLES),
        .SPAN_CYCLES  (SPAN_CYCLES),
        .SHIFT        (SHIFT)
    ) u_calc (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_ctrl_valid),
        .i_value       (i_ctrl_value),
        .o_target      (calc_target),
        .o_sat         (calc_sat),
        .o_target_valid(calc_tv)
    );

    // run_q holds the counter at 0 for one edge after reset so the first frame starts on the second edge
    always_comb begin
        boundary = run_q && cnt_q == LAST;
        cnt_d    = (!run_q || boundary) ? '0 : cnt_q + 16'd1;
        up       = tgt_q > duty_q;
        diff     = up ? tgt_q - duty_q : duty_q - tgt_q;
        step     = diff > SLEW ? SLEW : diff;
        duty_d   = !boundary ? duty_q : up ? duty_q + step : duty_q - step;
    end

    // A fresh result always wins over a coincident timeout tick
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        to_d    = to_q;
        if (calc_tv) begin
            state_d = TRACK;
            tgt_d   = calc_target;
            to_d    = '0;
        end else if (state_q == TRACK && boundary) begin
            to_d = to_q + 16'd1;
            if (to_q == TO_LAST) begin
                state_d = FAILSAFE;
                tgt_d   = CENTER;
                to_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            duty_q     <= CENTER;
            duty_out_q <= CENTER;
            pwm_q      <= 1'b0;
            fs_q       <= 1'b0;
            tgt_q      <= CENTER;
            to_q       <= '0;
            state_q    <= IDLE;
        end else begin
            run_q      <= 1'b1;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            duty_out_q <= duty_q;
            pwm_q      <= run_q && cnt_q < duty_q;
            fs_q       <= run_q && cnt_q == '0;
            tgt_q      <= tgt_d;
            to_q       <= to_d;
            state_q    <= state_d;
        end
    end

    assign o_pwm         = pwm_q;
    assign o_frame_start = fs_q;
    assign o_duty        = duty_out_q;
    assign o_sat         = calc_sat;
    assign o_timeout     = state_q == FAILSAFE && !calc_tv;

endmodule

// File: tb/tb_steering_pwm_driver.sv
// tb_steering_pwm_driver: per-frame scoreboard for duty, flags and PWM high time
module tb_steering_pwm_driver;
    import steering_pkg::*;

    localparam logic [CTRL_W-1:0] V10   = 48'd655360;
    localparam logic [CTRL_W-1:0] V1000 = 48'd65536000;
    localparam logic [CTRL_W-1:0] VNEG  = ~48'd65536000 + 48'd1;

    typedef struct {
        int   duty;
        logic sat;
        logic to;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_ctrl_valid = 1'b0;
    logic [CTRL_W-1:0] i_ctrl_value = '0;
    logic              o_pwm;
    logic              o_frame_start;
    logic [DUTY_W-1:0] o_duty;
    logic              o_sat;
    logic              o_timeout;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    steering_pwm_driver dut (
        .clk          (clk),
        .rst          (rst),
        .i_ctrl_valid (i_ctrl_valid),
        .i_ctrl_value (i_ctrl_value),
        .o_pwm        (o_pwm),
        .o_frame_start(o_frame_start),
        .o_duty       (o_duty),
        .o_sat        (o_sat),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_pwm", o_pwm, 0);
        check("rst_frame_start", o_frame_start, 0);
        check("rst_duty", o_duty, 75);
        check("rst_sat", o_sat, 0);
        check("rst_timeout", o_timeout, 0);
    endtask

    // Monitor: every frame start pops one expectation; high time of the finished frame is checked too
    initial begin
        int   hi;
        int   prev;
        exp_t e;
        hi   = 0;
        prev = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hi   = 0;
                prev = -1;
            end else begin
                if (o_frame_start) begin
                    if (prev >= 0)
                        check("frame_high_cycles", hi, prev);
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: frame start with empty scoreboard (t=%0t)", $time);
                        prev = -1;
                    end else begin
                        e = q.pop_front();
                        check("duty", o_duty, e.duty);
                        check("sat", o_sat, e.sat);
                        check("timeout", o_timeout, e.to);
                        prev = e.duty;
                    end
                    hi = 0;
                end
                hi += o_pwm;
            end
        end
    end

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = o_frame_start;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_start_wait: no frame start within 1100 cycles");
        end
    endtask

    // Called in a frame-start cycle: queue the next frame's expectation, optionally command at offset j
    task automatic step(input int d, input logic s, input logic t, input bit cmd = 1'b0,
                        input int j = 10, input logic [CTRL_W-1:0] v = '0, input bit chk = 1'b0);
        exp_t e;
        e.duty = d;
        e.sat  = s;
        e.to   = t;
        q.push_back(e);
        if (cmd) begin
            repeat (j) @(posedge clk);
            #1;
            i_ctrl_valid = 1'b1;
            i_ctrl_value = v;
            @(posedge clk);
            #1;
            i_ctrl_valid = 1'b0;
            if (chk)
                check("timeout_before_result", o_timeout, 1);
            @(posedge clk);
            #1;
            if (chk)
                check("timeout_cleared_with_result", o_timeout, 0);
        end
        wait_fs();
    endtask

    task automatic release_reset();
        exp_t e;
        e.duty = 75;
        e.sat  = 1'b0;
        e.to   = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_frame_start", o_frame_start, 0);
        check("first_edge_pwm", o_pwm, 0);
        @(posedge clk);
        #1;
        check("second_edge_frame_start", o_frame_start, 1);
        check("second_edge_pwm", o_pwm, 1);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_reset_vals();
        release_reset();
        repeat (20) step(75, 0, 0);
        step(80, 0, 0, 1, 10, V10);
        step(85, 0, 0);
        step(85, 0, 0);
        step(90, 1, 0, 1, 10, V1000);
        step(95, 1, 0);
        step(100, 1, 0);
        step(100, 1, 0);
        for (int d = 95; d >= 50; d -= 5)
            step(d, 1, 0, 1, 10, VNEG);
        for (int d = 55; d <= 85; d += 5)
            step(d, 0, 0, 1, 10, V10);
        repeat (6) step(85, 0, 0);
        step(85, 0, 1);
        step(80, 0, 1);
        step(75, 0, 1);
        step(80, 0, 0, 1, 10, V10, 1);
        step(85, 0, 0);
        step(85, 0, 0, 1, 996, '0);
        step(80, 0, 0);
        step(75, 0, 0);
        repeat (29) @(posedge clk);
        #1;
        check("pwm_high_before_reset", o_pwm, 1);
        #1 rst = 1'b0;
        #1 check_reset_vals();
        q.delete();
        repeat (3) @(posedge clk);
        release_reset();
        step(75, 0, 0);
        step(75, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
